// File: rtl/change_pkg.sv
// Shared types for the change dispenser: FSM states, coin denomination codes
// and their unit values.
package change_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EMIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DEN_NONE = 2'd0,
    DEN_1    = 2'd1,
    DEN_2    = 2'd2,
    DEN_5    = 2'd3
  } den_e;

  localparam logic [7:0] VAL_1 = 8'd1;
  localparam logic [7:0] VAL_2 = 8'd2;
  localparam logic [7:0] VAL_5 = 8'd5;

  function automatic logic [7:0] den_value(input den_e den);
    case (den)
      DEN_1:   return VAL_1;
      DEN_2:   return VAL_2;
      DEN_5:   return VAL_5;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counter: loads INV_INIT on reset or refill and counts
// down one per dispensed coin, never below zero.
module coin_inventory
  import change_pkg::*;
#(
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [INV_W-1:0] count,
  output logic             empty
);

  localparam logic [INV_W-1:0] INIT_VAL = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] ONE_VAL  = {{(INV_W-1){1'b0}}, 1'b1};

  logic [INV_W-1:0] count_r;

  // Counter register with synchronous reload and guarded decrement.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count_r <= INIT_VAL;
    end else if (dec && (count_r != {INV_W{1'b0}})) begin
      count_r <= count_r - ONE_VAL;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign empty = (count_r == {INV_W{1'b0}});

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a change amount, pays it out greedily as 5/2/1
// coin pulses from tracked inventories and reports any unpaid remainder.
module change_dispenser
  import change_pkg::*;
#(
  parameter int INV_W      = 6,
  parameter int INV_INIT   = 20,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rc_valid,
  input  logic [7:0]       rc_amount,
  output logic             rc_ready,
  input  logic             refill,
  output logic             coin_out,
  output logic [1:0]       coin_den,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [7:0]       shortfall,
  output logic [INV_W-1:0] inv_hi,
  output logic [INV_W-1:0] inv_mid,
  output logic [INV_W-1:0] inv_lo
);

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_e     state_r, state_next_s;
  logic [7:0] remaining_r, remaining_next_s;
  logic [7:0] gap_cnt_r, gap_cnt_next_s;
  den_e       sel_den_r, sel_den_next_s;
  den_e       pick_s;

  logic empty_hi_s, empty_mid_s, empty_lo_s;
  logic dec_hi_s, dec_mid_s, dec_lo_s;
  logic load_s;

  logic       rc_ready_r;
  logic       busy_r;
  logic       coin_out_r;
  logic [1:0] coin_den_r;
  logic       done_r;
  logic       short_r;
  logic [7:0] shortfall_r;

  // Refill only counts in IDLE; a coin leaves inventory at the end of EMIT.
  assign load_s    = refill && (state_r == ST_IDLE);
  assign dec_hi_s  = (state_r == ST_EMIT) && (sel_den_r == DEN_5);
  assign dec_mid_s = (state_r == ST_EMIT) && (sel_den_r == DEN_2);
  assign dec_lo_s  = (state_r == ST_EMIT) && (sel_den_r == DEN_1);

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_hi (
    .clk(clk), .reset(reset), .load(load_s), .dec(dec_hi_s),
    .count(inv_hi), .empty(empty_hi_s)
  );

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_mid (
    .clk(clk), .reset(reset), .load(load_s), .dec(dec_mid_s),
    .count(inv_mid), .empty(empty_mid_s)
  );

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_lo (
    .clk(clk), .reset(reset), .load(load_s), .dec(dec_lo_s),
    .count(inv_lo), .empty(empty_lo_s)
  );

  // Greedy pick: largest coin that fits the remainder and is still in stock.
  always_comb begin
    pick_s = DEN_NONE;
    if ((remaining_r >= VAL_5) && !empty_hi_s) begin
      pick_s = DEN_5;
    end else if ((remaining_r >= VAL_2) && !empty_mid_s) begin
      pick_s = DEN_2;
    end else if ((remaining_r >= VAL_1) && !empty_lo_s) begin
      pick_s = DEN_1;
    end else begin
      pick_s = DEN_NONE;
    end
  end

  // Next-state logic for the payout sequencer.
  always_comb begin
    state_next_s     = state_r;
    remaining_next_s = remaining_r;
    gap_cnt_next_s   = gap_cnt_r;
    sel_den_next_s   = sel_den_r;
    case (state_r)
      ST_IDLE: begin
        if (rc_valid) begin
          remaining_next_s = rc_amount;
          state_next_s     = ST_SELECT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (remaining_r == 8'd0) begin
          state_next_s = ST_FINISH;
        end else if (pick_s != DEN_NONE) begin
          sel_den_next_s = pick_s;
          state_next_s   = ST_EMIT;
        end else begin
          state_next_s = ST_FINISH;
        end
      end
      ST_EMIT: begin
        remaining_next_s = remaining_r - den_value(sel_den_r);
        if (GAP_CYCLES == 0) begin
          state_next_s = ST_SELECT;
        end else begin
          gap_cnt_next_s = 8'd0;
          state_next_s   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_next_s = ST_SELECT;
        end else begin
          gap_cnt_next_s = gap_cnt_r + 8'd1;
        end
      end
      ST_FINISH: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, remainder, gap counter and latched denomination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      remaining_r <= 8'd0;
      gap_cnt_r   <= 8'd0;
      sel_den_r   <= DEN_NONE;
    end else begin
      state_r     <= state_next_s;
      remaining_r <= remaining_next_s;
      gap_cnt_r   <= gap_cnt_next_s;
      sel_den_r   <= sel_den_next_s;
    end
  end

  // Outputs are flopped from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rc_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      coin_out_r  <= 1'b0;
      coin_den_r  <= DEN_NONE;
      done_r      <= 1'b0;
      short_r     <= 1'b0;
      shortfall_r <= 8'd0;
    end else begin
      rc_ready_r <= (state_next_s == ST_IDLE);
      busy_r     <= (state_next_s != ST_IDLE);
      coin_out_r <= (state_next_s == ST_EMIT);
      coin_den_r <= (state_next_s == ST_EMIT) ? sel_den_next_s : DEN_NONE;
      done_r     <= (state_next_s == ST_FINISH);
      if (state_next_s == ST_FINISH) begin
        short_r     <= (remaining_next_s != 8'd0);
        shortfall_r <= remaining_next_s;
      end else begin
        short_r     <= 1'b0;
        shortfall_r <= shortfall_r;
      end
    end
  end

  assign rc_ready  = rc_ready_r;
  assign busy      = busy_r;
  assign coin_out  = coin_out_r;
  assign coin_den  = coin_den_r;
  assign done      = done_r;
  assign short     = short_r;
  assign shortfall = shortfall_r;

endmodule
